// File: rtl/dds_cmd_bridge_if.sv
// Bus bundle between the DDS command bridge and its FIFOs / serial register engine.
// Handshakes: a byte moves only on a rising clk edge where valid and ready are both high;
// the source holds data and valid stable until that edge.
interface dds_cmd_bridge_if #(
    parameter int NCH = 4,
    parameter int DW  = 64
);
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready;
    logic           wr_start;
    logic [NCH-1:0] wr_cs;
    logic [7:0]     wr_addr;
    logic [DW-1:0]  wr_din;
    logic [DW-1:0]  wr_dout;
    logic           wr_done;
    logic           busy;
    logic [7:0]     err_cnt;
    logic [2:0]     dbg_state;

    modport master (
        input  rx_data, rx_valid, tx_ready, wr_dout, wr_done,
        output rx_ready, tx_data, tx_valid, wr_start, wr_cs, wr_addr, wr_din,
               busy, err_cnt, dbg_state
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, wr_dout, wr_done,
        input  rx_ready, tx_data, tx_valid, wr_start, wr_cs, wr_addr, wr_din,
               busy, err_cnt, dbg_state
    );
endinterface

// File: rtl/dds_cmd_bridge.sv
// Byte-stream command bridge: parses channel/instruction/data packets, issues one
// serial register access per packet and returns an ack byte or the read data.
module dds_cmd_bridge #(
    parameter int NCH     = 4,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    dds_cmd_bridge_if.master  bus
);
    localparam int NB = DW / 8;
    localparam int TW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GET_ADDR = 3'd1;
    localparam logic [2:0] S_GET_DATA = 3'd2;
    localparam logic [2:0] S_CHECK    = 3'd3;
    localparam logic [2:0] S_ISSUE    = 3'd4;
    localparam logic [2:0] S_WAIT     = 3'd5;
    localparam logic [2:0] S_RESP     = 3'd6;

    logic [2:0]     state;
    logic [7:0]     chan;
    logic [7:0]     addr_q;
    logic [DW-1:0]  din_q;
    logic [DW-1:0]  rd_sh;
    logic [3:0]     rx_cnt;
    logic [3:0]     tx_left;
    logic [TW-1:0]  idle_cnt;
    logic [NCH-1:0] cs_q;
    logic [7:0]     tx_data_q;
    logic [7:0]     err_q;
    logic           tx_valid_q;
    logic           start_q;

    logic in_rx, in_pkt, rx_fire, tx_fire, timeout_hit, chan_ok, err_inc;

    assign in_rx       = (state == S_IDLE) || (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign in_pkt      = (state == S_GET_ADDR) || (state == S_GET_DATA);
    assign bus.rx_ready = rst & in_rx;
    assign rx_fire     = bus.rx_valid & bus.rx_ready;
    assign tx_fire     = tx_valid_q & bus.tx_ready;
    assign timeout_hit = in_pkt && !rx_fire && (idle_cnt == TW'(TIMEOUT - 1));
    assign chan_ok     = (chan < 8'(NCH));
    // Both error sources share one increment so a coincidence counts once.
    assign err_inc     = timeout_hit || ((state == S_CHECK) && !chan_ok);

    assign bus.tx_data   = tx_data_q;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.wr_start  = start_q;
    assign bus.wr_cs     = cs_q;
    assign bus.wr_addr   = addr_q;
    assign bus.wr_din    = din_q;
    assign bus.busy      = (state != S_IDLE);
    assign bus.err_cnt   = err_q;
    assign bus.dbg_state = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            chan       <= 8'd0;
            addr_q     <= 8'd0;
            din_q      <= '0;
            rd_sh      <= '0;
            rx_cnt     <= 4'd0;
            tx_left    <= 4'd0;
            idle_cnt   <= '0;
            cs_q       <= '0;
            tx_data_q  <= 8'd0;
            err_q      <= 8'd0;
            tx_valid_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;

            if (err_inc && (err_q != 8'hFF))
                err_q <= err_q + 8'd1;

            if (in_pkt && !rx_fire && !timeout_hit)
                idle_cnt <= idle_cnt + 1'b1;
            else
                idle_cnt <= '0;

            case (state)
                S_IDLE: begin
                    if (rx_fire) begin
                        chan  <= bus.rx_data;
                        state <= S_GET_ADDR;
                    end
                end
                S_GET_ADDR: begin
                    if (rx_fire) begin
                        addr_q <= bus.rx_data;
                        rx_cnt <= 4'd0;
                        state  <= bus.rx_data[7] ? S_CHECK : S_GET_DATA;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    // First data byte ends up in the top byte after NB shifts.
                    if (rx_fire) begin
                        din_q  <= (din_q << 8) | DW'(bus.rx_data);
                        rx_cnt <= rx_cnt + 4'd1;
                        if (rx_cnt == 4'(NB - 1))
                            state <= S_CHECK;
                    end else if (timeout_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_CHECK: begin
                    if (chan_ok) begin
                        start_q <= 1'b1;
                        cs_q    <= NCH'(1) << chan;
                        state   <= S_ISSUE;
                    end else begin
                        tx_data_q  <= 8'hEE;
                        tx_valid_q <= 1'b1;
                        tx_left    <= 4'd1;
                        state      <= S_RESP;
                    end
                end
                S_ISSUE: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.wr_done) begin
                        cs_q       <= '0;
                        tx_valid_q <= 1'b1;
                        state      <= S_RESP;
                        if (addr_q[7]) begin
                            tx_data_q <= bus.wr_dout[DW-1 -: 8];
                            rd_sh     <= bus.wr_dout << 8;
                            tx_left   <= 4'(NB);
                        end else begin
                            tx_data_q <= 8'hA5;
                            tx_left   <= 4'd1;
                        end
                    end
                end
                S_RESP: begin
                    if (tx_fire) begin
                        if (tx_left == 4'd1) begin
                            tx_valid_q <= 1'b0;
                            state      <= S_IDLE;
                        end else begin
                            tx_data_q <= rd_sh[DW-1 -: 8];
                            rd_sh     <= rd_sh << 8;
                            tx_left   <= tx_left - 4'd1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dds_cmd_bridge.sv
// Directed bench for dds_cmd_bridge at NCH=4, DW=32, TIMEOUT=16.
module tb_dds_cmd_bridge;
    logic clk = 1'b0;
    logic rst = 1'b0;

    dds_cmd_bridge_if #(.NCH(4), .DW(32)) bus ();

    dds_cmd_bridge #(.NCH(4), .DW(32), .TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vec_cnt   = 0;
    int miss_cnt  = 0;
    int start_cnt = 0;
    int tx_seen   = 0;
    int hold_bad  = 0;
    int unstable  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (bus.wr_start === 1'b1) start_cnt++;
        if (bus.tx_valid === 1'b1) tx_seen++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (bus.rx_ready === 1'b1) begin
            @(posedge clk); #1;
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok);
        int n = 0;
        while (bus.wr_start !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        ok = (bus.wr_start === 1'b1);
    endtask

    task automatic pulse_done(input logic [31:0] dout, input int delay);
        logic [3:0]  cs0 = bus.wr_cs;
        logic [7:0]  a0  = bus.wr_addr;
        logic [31:0] d0  = bus.wr_din;
        repeat (delay) begin
            @(posedge clk); #1;
            if (bus.wr_cs !== cs0 || bus.wr_addr !== a0 || bus.wr_din !== d0) hold_bad++;
        end
        bus.wr_dout = dout;
        bus.wr_done = 1'b1;
        @(posedge clk); #1;
        bus.wr_done = 1'b0;
        bus.wr_dout = '0;
    endtask

    task automatic recv_bytes(input int n, input int hold);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            logic [7:0] d0;
            while (bus.tx_valid !== 1'b1 && w < 20) begin
                @(posedge clk); #1; w++;
            end
            if (bus.tx_valid !== 1'b1) break;
            d0 = bus.tx_data;
            repeat (hold) begin
                @(posedge clk); #1;
                if (bus.tx_data !== d0 || bus.tx_valid !== 1'b1) unstable++;
            end
            bus.tx_ready = 1'b1;
            @(posedge clk); #1;
            bus.tx_ready = 1'b0;
            got_q.push_back(d0);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vec_cnt++; if (bus.rx_ready !== 1'b0) begin miss_cnt++; $display("FAIL reset_rx_ready_low: got %b expected 0", bus.rx_ready); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (bus.rx_ready !== 1'b1) begin miss_cnt++; $display("FAIL reset_rx_ready_high: got %b expected 1", bus.rx_ready); end
        @(posedge clk); #1;
        vec_cnt++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.wr_start !== 1'b0 || bus.busy !== 1'b0) begin
            miss_cnt++;
            $display("FAIL reset_ctrl: got tx_valid=%b tx_data=%h wr_start=%b busy=%b expected 0/00/0/0",
                     bus.tx_valid, bus.tx_data, bus.wr_start, bus.busy);
        end
        vec_cnt++;
        if (bus.wr_cs !== 4'h0 || bus.wr_addr !== 8'h00 || bus.wr_din !== 32'h0 || bus.err_cnt !== 8'h00 || bus.dbg_state !== 3'd0) begin
            miss_cnt++;
            $display("FAIL reset_regs: got cs=%b addr=%h din=%h err=%h state=%0d expected all zero",
                     bus.wr_cs, bus.wr_addr, bus.wr_din, bus.err_cnt, bus.dbg_state);
        end
    endtask

    task automatic run_write(input logic [7:0] pkt[6], input logic [3:0] cs, input logic [31:0] din, input string tag);
        bit ok;
        int s0 = start_cnt;
        got_q.delete();
        exp_q.delete();
        exp_q.push_back(8'hA5);
        hold_bad = 0;
        foreach (pkt[i]) send_byte(pkt[i]);
        wait_start(ok);
        vec_cnt++; if (!ok) begin miss_cnt++; $display("FAIL %s_start: got no wr_start expected a pulse", tag); end
        vec_cnt++;
        if (bus.wr_cs !== cs || bus.wr_addr !== pkt[1] || bus.wr_din !== din) begin
            miss_cnt++;
            $display("FAIL %s_access: got cs=%b addr=%h din=%h expected cs=%b addr=%h din=%h",
                     tag, bus.wr_cs, bus.wr_addr, bus.wr_din, cs, pkt[1], din);
        end
        pulse_done(32'h0, 3);
        vec_cnt++; if (hold_bad !== 0) begin miss_cnt++; $display("FAIL %s_hold: got %0d unstable cycles expected 0", tag, hold_bad); end
        recv_bytes(1, 0);
        vec_cnt++; if (bus.busy !== 1'b0 || bus.wr_cs !== 4'h0) begin miss_cnt++; $display("FAIL %s_idle: got busy=%b cs=%b expected 0/0000", tag, bus.busy, bus.wr_cs); end
        vec_cnt++;
        if (got_q.size() != 1 || got_q[0] !== exp_q[0]) begin
            miss_cnt++;
            $display("FAIL %s_resp: got %0d bytes first=%h expected 1 byte %h", tag, got_q.size(),
                     (got_q.size() > 0) ? got_q[0] : 8'hxx, exp_q[0]);
        end
        vec_cnt++; if (start_cnt - s0 != 1) begin miss_cnt++; $display("FAIL %s_start_count: got %0d expected 1", tag, start_cnt - s0); end
    endtask

    task automatic test_write();
        logic [7:0] pkt[6] = '{8'h02, 8'h0E, 8'h11, 8'h22, 8'h33, 8'h44};
        run_write(pkt, 4'b0100, 32'h11223344, "write");
    endtask

    task automatic test_read();
        bit ok;
        got_q.delete();
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        unstable = 0;
        send_byte(8'h01);
        send_byte(8'h8E);
        wait_start(ok);
        vec_cnt++;
        if (!ok || bus.wr_cs !== 4'b0010 || bus.wr_addr !== 8'h8E) begin
            miss_cnt++;
            $display("FAIL read_access: got start=%b cs=%b addr=%h expected 1/0010/8e", ok, bus.wr_cs, bus.wr_addr);
        end
        pulse_done(32'hDEADBEEF, 2);
        recv_bytes(4, 3);
        vec_cnt++; if (got_q.size() != 4) begin miss_cnt++; $display("FAIL read_count: got %0d bytes expected 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            vec_cnt++;
            if (got_q[i] !== exp_q[i]) begin miss_cnt++; $display("FAIL read_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]); end
        end
        vec_cnt++; if (unstable !== 0) begin miss_cnt++; $display("FAIL read_tx_stable: got %0d changes expected 0", unstable); end
    endtask

    task automatic test_bad_channel();
        logic [7:0] pkt[6] = '{8'h05, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00};
        int s0 = start_cnt;
        got_q.delete();
        foreach (pkt[i]) send_byte(pkt[i]);
        recv_bytes(1, 0);
        vec_cnt++;
        if (got_q.size() != 1 || got_q[0] !== 8'hEE) begin
            miss_cnt++;
            $display("FAIL bad_resp: got %0d bytes first=%h expected 1 byte ee", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
        end
        vec_cnt++; if (start_cnt != s0) begin miss_cnt++; $display("FAIL bad_no_start: got %0d pulses expected 0", start_cnt - s0); end
        vec_cnt++; if (bus.err_cnt !== 8'd1) begin miss_cnt++; $display("FAIL bad_err_cnt: got %0d expected 1", bus.err_cnt); end
    endtask

    task automatic test_timeout();
        logic [7:0] pkt[6] = '{8'h03, 8'h0E, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        int t0 = tx_seen;
        send_byte(8'h00);
        send_byte(8'h0E);
        send_byte(8'h11);
        repeat (15) begin @(posedge clk); #1; end
        vec_cnt++; if (bus.busy !== 1'b1) begin miss_cnt++; $display("FAIL timeout_early: got busy=%b after 15 idle expected 1", bus.busy); end
        @(posedge clk); #1;
        vec_cnt++; if (bus.busy !== 1'b0 || bus.dbg_state !== 3'd0) begin miss_cnt++; $display("FAIL timeout_idle: got busy=%b state=%0d expected 0/0", bus.busy, bus.dbg_state); end
        vec_cnt++; if (bus.err_cnt !== 8'd2) begin miss_cnt++; $display("FAIL timeout_err_cnt: got %0d expected 2", bus.err_cnt); end
        vec_cnt++; if (tx_seen != t0) begin miss_cnt++; $display("FAIL timeout_no_tx: got %0d tx cycles expected 0", tx_seen - t0); end
        run_write(pkt, 4'b1000, 32'hAABBCCDD, "post_timeout");
    endtask

    task automatic test_reset_mid_access();
        bit ok;
        int t0 = tx_seen;
        send_byte(8'h01);
        send_byte(8'h8E);
        wait_start(ok);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wr_dout = 32'hDEADBEEF;
        bus.wr_done = 1'b1;
        @(posedge clk); #1;
        bus.wr_done = 1'b0;
        bus.wr_dout = '0;
        repeat (5) begin @(posedge clk); #1; end
        vec_cnt++;
        if (bus.busy !== 1'b0 || bus.dbg_state !== 3'd0 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.wr_start !== 1'b0) begin
            miss_cnt++;
            $display("FAIL rstmid_ctrl: got busy=%b state=%0d tx_valid=%b tx_data=%h start=%b expected all zero",
                     bus.busy, bus.dbg_state, bus.tx_valid, bus.tx_data, bus.wr_start);
        end
        vec_cnt++;
        if (bus.wr_cs !== 4'h0 || bus.wr_addr !== 8'h00 || bus.wr_din !== 32'h0 || bus.err_cnt !== 8'h00) begin
            miss_cnt++;
            $display("FAIL rstmid_regs: got cs=%b addr=%h din=%h err=%0d expected all zero",
                     bus.wr_cs, bus.wr_addr, bus.wr_din, bus.err_cnt);
        end
        vec_cnt++; if (tx_seen != t0) begin miss_cnt++; $display("FAIL rstmid_no_tx: got %0d tx cycles expected 0", tx_seen - t0); end
    endtask

    task automatic test_saturation();
        int bad_resp = 0;
        got_q.delete();
        for (int p = 0; p < 300; p++) begin
            send_byte(8'h07);
            send_byte(8'h8E);
            recv_bytes(1, 0);
            if (got_q.size() != p + 1 || got_q[p] !== 8'hEE) bad_resp++;
            if (p == 253) begin
                vec_cnt++; if (bus.err_cnt !== 8'd254) begin miss_cnt++; $display("FAIL sat_254: got %0d expected 254", bus.err_cnt); end
            end
            if (p == 254) begin
                vec_cnt++; if (bus.err_cnt !== 8'd255) begin miss_cnt++; $display("FAIL sat_255: got %0d expected 255", bus.err_cnt); end
            end
        end
        vec_cnt++; if (bus.err_cnt !== 8'd255) begin miss_cnt++; $display("FAIL sat_hold: got %0d expected 255", bus.err_cnt); end
        vec_cnt++; if (bad_resp != 0) begin miss_cnt++; $display("FAIL sat_resp: got %0d bad responses expected 0", bad_resp); end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b0;
        bus.wr_dout  = '0;
        bus.wr_done  = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_bad_channel();
        test_timeout();
        test_reset_mid_access();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule

// File: doc/dds_cmd_bridge.md
DDS_CMD_BRIDGE -- requirements
Module: dds_cmd_bridge

Interface
REQ-001 SHALL have parameter NCH, default 4: number of DDS channels (one chip-select each), range 1..8.
REQ-002 SHALL have parameter DW, default 64: register data width in bits, a multiple of 8, range 8..64.
REQ-003 SHALL have parameter TIMEOUT, default 1000000: inter-byte timeout in clk cycles, at least 2.
REQ-004 SHALL have one clock and a synchronous, active-low reset, named as below.
REQ-005 SHALL have clk  in  1  system clock; all logic on its rising edge.
REQ-006 SHALL have rst  in  1  synchronous active-low reset.
REQ-007 SHALL have rx_data  in  8  command byte from the receive FIFO.
REQ-008 SHALL have rx_valid  in  1  rx_data is valid.
REQ-009 SHALL have rx_ready  out  1  bridge accepts rx_data this cycle.
REQ-010 SHALL have tx_data  out  8  response byte to the transmit FIFO.
REQ-011 SHALL have tx_valid  out  1  tx_data is valid.
REQ-012 SHALL have tx_ready  in  1  transmit FIFO accepts tx_data.
REQ-013 SHALL have wr_start  out  1  one-cycle pulse that starts a serial register access.
REQ-014 SHALL have wr_cs  out  NCH  one-hot channel select.
REQ-015 SHALL have wr_addr  out  8  instruction byte; bit7=1 means read.
REQ-016 SHALL have wr_din  out  DW  write data.
REQ-017 SHALL have wr_dout  in  DW  read data; valid when wr_done is high.
REQ-018 SHALL have wr_done  in  1  access complete.
REQ-019 SHALL have busy  out  1  high when not in IDLE.
REQ-020 SHALL have err_cnt  out  8  saturating error counter.

Function
REQ-021 Byte transfer SHALL occur only on a cycle where rx_valid and rx_ready are both high; tx handshake likewise uses tx_valid and tx_ready.
REQ-022 Packet format SHALL be: byte0 = channel index, byte1 = wr_addr; if wr_addr[7]=0, followed by DW/8 data bytes, MSB first; if wr_addr[7]=1, no data bytes.
REQ-023 FSM states and transitions SHALL be: IDLE -(byte0)-> GET_ADDR -(byte1)-> GET_DATA for a write, or directly to CHECK for a read; GET_DATA -(last data byte)-> CHECK; CHECK -> ISSUE or RESP; ISSUE -> WAIT; WAIT -(wr_done)-> RESP; RESP -(last byte handshaken)-> IDLE.
REQ-024 rx_ready SHALL be high only in IDLE, GET_ADDR and GET_DATA.
REQ-025 Data bytes SHALL shift into wr_din from the LSB end, so the first byte lands in bits [DW-1:DW-8].
REQ-026 CHECK SHALL take one cycle: channel < NCH goes to ISSUE; otherwise response 0xEE, err_cnt increments, and no access is issued.
REQ-027 In ISSUE, wr_start SHALL be high for exactly one cycle, and wr_cs, wr_addr and wr_din SHALL be valid from that cycle.
REQ-028 wr_cs, wr_addr and wr_din SHALL hold stable until the cycle after wr_done.
REQ-029 wr_done outside WAIT SHALL be ignored.
REQ-030 In WAIT, on wr_done=1 the bridge SHALL capture wr_dout for a read and move to RESP on the next cycle.
REQ-031 RESP SHALL send 0xA5 for a write (one byte), or DW/8 bytes of captured read data, MSB first.
REQ-032 tx_data SHALL stay stable while tx_valid=1 and tx_ready=0; the next byte is presented the cycle after a handshake.
REQ-033 In GET_ADDR and GET_DATA, an idle counter SHALL clear on each accepted byte. On reaching TIMEOUT-1, the FSM goes to IDLE, the partial packet is discarded, err_cnt increments, and no response is sent.
REQ-034 err_cnt SHALL saturate at 255; when both error sources coincide, it increments once.
REQ-035 wr_cs SHALL be all-zero whenever no access is in progress (IDLE through CHECK, and RESP).
REQ-036 There SHALL be no timeout in WAIT; wr_done is guaranteed by the serial engine.

Reset
REQ-037 On rst=0 at a clock edge, the FSM SHALL go to IDLE and the outputs SHALL be: rx_ready=0 during reset then 1, tx_valid=0, tx_data=0, wr_start=0, wr_cs=0, wr_addr=0, wr_din=0, busy=0, err_cnt=0, timeout counter=0.
REQ-038 Reset mid-packet or mid-access SHALL discard all state; a late wr_done after reset is ignored.

Verification (NCH=4, DW=32, TIMEOUT=16)
REQ-039 Write: bytes 02,0E,11,22,33,44 -> one wr_start, wr_cs=0100, wr_addr=0E, wr_din=11223344; wr_done -> tx byte A5; busy falls after the handshake.
REQ-040 Read: bytes 01,8E; wr_dout=DEADBEEF with wr_done -> wr_cs=0010, wr_addr=8E; tx bytes DE,AD,BE,EF in order; tx_ready held low for 3 cycles per byte -> tx_data stable.
REQ-041 Bad channel: bytes 05,0E,00,00,00,00 -> no wr_start; tx byte EE; err_cnt=1.
REQ-042 Timeout: bytes 00,0E,11 then 16 idle cycles -> return to IDLE, no tx, err_cnt +1; next full packet processes normally.
REQ-043 Reset: assert rst during WAIT, then pulse wr_done -> all outputs at reset values, no tx.
REQ-044 Saturation: 300 bad-channel packets -> err_cnt=255.
